// File: rtl/sum_latch_uart_tx_if.sv
// Operand/control and status bundle for sum_latch_uart_tx.
// The master drives operands and commands; the slave (the datapath) returns status and the TX line.
interface sum_latch_uart_tx_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic [1:0]        op;
  logic              clr;
  logic              latch;
  logic [DATA_W-1:0] acc;
  logic              ovf;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (
    output in_valid, in_data, op, clr, latch,
    input  acc, ovf, busy, done, tx
  );

  modport slave (
    input  in_valid, in_data, op, clr, latch,
    output acc, ovf, busy, done, tx
  );
endinterface

// File: rtl/sum_latch_uart_tx.sv
// Accumulator with add/sub/xor/load; on latch, snapshots the value and sends it as 8N1 UART, LSB byte first.
//   state | meaning
//   IDLE  | line high, waiting for latch
//   START | start bit (line low) of byte byte_q
//   DATA  | data bit bit_q of byte byte_q, LSB first
//   STOP  | stop bit (line high); then next byte or back to IDLE
module sum_latch_uart_tx #(
  parameter int DATA_W   = 16,
  parameter int BAUD_DIV = 104
) (
  input  logic               clk,
  input  logic               rst,
  sum_latch_uart_tx_if.slave bus
);
  localparam int NBYTES = DATA_W / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [DATA_W-1:0] acc_q;
  logic              ovf_q;
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   dif_w;

  assign operand = DATA_W'(bus.in_data);
  assign sum_w   = {1'b0, acc_q} + {1'b0, operand};
  assign dif_w   = {1'b0, acc_q} - {1'b0, operand};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      case (bus.op)
        2'b00: begin
          acc_q <= sum_w[DATA_W-1:0];
          ovf_q <= ovf_q | sum_w[DATA_W];
        end
        2'b01: begin
          acc_q <= dif_w[DATA_W-1:0];
          ovf_q <= ovf_q | dif_w[DATA_W];
        end
        2'b10:   acc_q <= acc_q ^ operand;
        default: acc_q <= operand;
      endcase
    end
  end

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [BYTE_W-1:0] byte_q, byte_n;
  logic [DATA_W-1:0] snap_q;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              tx_q, tx_n;
  logic              snap_load;
  logic [DATA_W-1:0] cur_word;
  logic              baud_end;
  logic [2:0]        bit_inc;

  assign cur_word = snap_q >> {byte_q, 3'b000};
  assign baud_end = (baud_q == CNT_W'(BAUD_DIV - 1));
  assign bit_inc  = bit_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      tx_q    <= tx_n;
      if (snap_load) snap_q <= acc_q;
    end
  end

  // tx is registered: each branch sets the level the line holds during the coming cycle
  always_comb begin
    state_n   = state_q;
    baud_n    = baud_q;
    bit_n     = bit_q;
    byte_n    = byte_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    tx_n      = tx_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (bus.latch) begin
          snap_load = 1'b1;
          state_n   = START;
          baud_n    = '0;
          byte_n    = '0;
          busy_n    = 1'b1;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = cur_word[0];
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_inc;
            tx_n  = cur_word[bit_inc];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_n = '0;
          if (byte_q < BYTE_W'(NBYTES - 1)) begin
            byte_n  = byte_q + 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.acc  = acc_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tx   = tx_q;
endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Self-checking bench for sum_latch_uart_tx (DATA_W=16, BAUD_DIV=4): vector table, corner sequences,
// and random ops against an arithmetic model with frame waveforms rebuilt from the snapshot value.
module tb_sum_latch_uart_tx;
  localparam int DW    = 16;
  localparam int BD    = 4;
  localparam int NB    = DW / 8;
  localparam int FRAME = NB * 10 * BD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_latch_uart_tx_if #(.DATA_W(DW)) bus ();

  sum_latch_uart_tx #(.DATA_W(DW), .BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  typedef struct {
    logic        clr;
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  data;
    logic [15:0] acc;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic c, input logic v, input logic [1:0] o, input logic [7:0] d);
    int s;
    if (c) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end else if (v) begin
      case (o)
        2'd0: begin
          s = int'(m_acc) + int'(d);
          if (s > 65535) m_ovf = 1'b1;
          m_acc = 16'(s);
        end
        2'd1: begin
          s = int'(m_acc) - int'(d);
          if (s < 0) m_ovf = 1'b1;
          m_acc = 16'(s);
        end
        2'd2: m_acc = m_acc ^ {8'h00, d};
        default: m_acc = {8'h00, d};
      endcase
    end
  endtask

  task automatic apply(input logic c, input logic v, input logic [1:0] o, input logic [7:0] d);
    bus.clr = c; bus.in_valid = v; bus.op = o; bus.in_data = d;
    step();
    model_op(c, v, o, d);
    bus.clr = 1'b0; bus.in_valid = 1'b0;
  endtask

  // mode 0: no ops, 1: add 01 on the latch edge only, 2: add 01 every cycle of the frame
  task automatic run_frame(input int mode, input bit pulses, input string name);
    logic [15:0] snap;
    bit q[$];
    bit e[$];
    int busy_cnt, done_cnt, bad;
    bit finished;
    snap = m_acc;
    bus.latch = 1'b1; bus.in_valid = (mode != 0); bus.op = 2'd0; bus.in_data = 8'h01;
    step();
    model_op(1'b0, mode != 0, 2'd0, 8'h01);
    bus.latch = 1'b0;
    if (mode != 2) bus.in_valid = 1'b0;
    busy_cnt = 0; done_cnt = 0; finished = 0;
    for (int c = 0; c < FRAME + 40 && !finished; c++) begin
      if (bus.done) done_cnt++;
      if (bus.busy) begin
        q.push_back(bus.tx);
        busy_cnt++;
      end else begin
        finished = 1;
      end
      if (!finished) begin
        bus.latch = pulses && (c % 7 == 3);
        step();
        if (mode == 2) model_op(1'b0, 1'b1, 2'd0, 8'h01);
      end
    end
    bus.latch = 1'b0; bus.in_valid = 1'b0;
    step();
    if (bus.done) done_cnt++;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < BD; k++) e.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < BD; k++) e.push_back(snap[8*b+i]);
      for (int k = 0; k < BD; k++) e.push_back(1'b1);
    end
    bad = (q.size() == e.size()) ? 0 : 1000;
    for (int i = 0; i < q.size() && i < e.size(); i++) if (q[i] !== e[i]) bad++;
    chk({name, "_ended"}, 32'(finished), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME));
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, "_wave_errs"}, 32'(bad), 32'd0);
    chk({name, "_acc"}, 32'(bus.acc), 32'(m_acc));
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.op = '0; bus.clr = 1'b0; bus.latch = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", 32'(bus.acc), 32'h0);
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_tx", 32'(bus.tx), 32'h1);
    rst = 1'b0;
    step();

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 16'h00FF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 16'h01FE, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 8'h02, 16'h0200, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 8'h01, 16'h0001, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h02, 16'hFFFF, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 8'h0F, 16'hFFF0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 8'h55, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 8'h77, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h80, 16'h0080, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 8'h81, 16'hFFFF, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 8'h01, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 8'h00, 16'h0000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd3, 8'hAA, 16'h00AA, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 8'hFF, 16'h0055, 1'b0};
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].clr, vecs[i].valid, vecs[i].op, vecs[i].data);
      chk($sformatf("vec%0d_acc", i), 32'(bus.acc), 32'(vecs[i].acc));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
    end

    // 0x0200 goes out as 00 then 02
    apply(1'b1, 1'b0, 2'd0, 8'h00);
    apply(1'b0, 1'b1, 2'd0, 8'hFF);
    apply(1'b0, 1'b1, 2'd0, 8'hFF);
    apply(1'b0, 1'b1, 2'd0, 8'h02);
    chk("t2_acc", 32'(bus.acc), 32'h0200);
    run_frame(0, 1'b0, "t2");

    // 0x1234 = 18*0xFF + 0x46; counting and latch pulses continue during the frame
    apply(1'b1, 1'b0, 2'd0, 8'h00);
    repeat (18) apply(1'b0, 1'b1, 2'd0, 8'hFF);
    apply(1'b0, 1'b1, 2'd0, 8'h46);
    chk("t4_acc", 32'(bus.acc), 32'h1234);
    run_frame(2, 1'b1, "t4");
    chk("t4_acc_counted", 32'(bus.acc), 32'h1234 + 32'(FRAME) + 32'd1);

    apply(1'b0, 1'b1, 2'd3, 8'hAA);
    run_frame(1, 1'b0, "t5");
    chk("t5_acc", 32'(bus.acc), 32'h00AB);

    // reset 30 cycles into a frame
    apply(1'b0, 1'b1, 2'd3, 8'h5A);
    bus.latch = 1'b1;
    step();
    bus.latch = 1'b0;
    repeat (29) step();
    chk("t6_busy_before", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_tx", 32'(bus.tx), 32'h1);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_done", 32'(bus.done), 32'h0);
    chk("t6_acc", 32'(bus.acc), 32'h0);
    step();
    chk("t6_done_held", 32'(bus.done), 32'h0);
    rst = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    step();
    chk("t6_done_after", 32'(bus.done), 32'h0);
    apply(1'b0, 1'b1, 2'd3, 8'h3C);
    apply(1'b0, 1'b1, 2'd1, 8'h01);
    run_frame(0, 1'b0, "t6_new");

    for (int i = 0; i < 300; i++) begin
      logic c, v;
      logic [1:0] o;
      logic [7:0] d;
      c = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      apply(c, v, o, d);
      chk("rnd_acc", 32'(bus.acc), 32'(m_acc));
      chk("rnd_ovf", 32'(bus.ovf), 32'(m_ovf));
    end
    run_frame(2, 1'b1, "rnd_frame_a");
    apply(1'b0, 1'b1, 2'd3, 8'($urandom_range(0, 255)));
    run_frame(1, 1'b1, "rnd_frame_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
